// File: rtl/store_rmw_unit.sv
// Store path to a word-only data memory: SW writes directly, SB/SH read the
// word, merge the new lane(s) and write it back. Stalls via req_ready.
module store_rmw_unit #(
  parameter int BIG_ENDIAN  = 0,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

  state_t      state_r;
  state_t      state_s;
  logic [15:0] data_r;
  logic        is_byte_r;
  logic [1:0]  lo_r;
  logic [7:0]  cnt_r;
  logic        accept_s;
  logic        illegal_s;
  logic        timeout_s;
  logic        rd_s;
  logic        wr_s;
  logic        done_s;
  logic        err_s;

  // Replace the addressed byte/half of the old word; lane order depends on endianness.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [15:0] data_w,
                                             input logic        is_byte_w,
                                             input logic [1:0]  lo_w);
    logic [31:0] m;
    logic [1:0]  lane;
    logic        hslot;
    m = old_w;
    if (BIG_ENDIAN != 0) begin
      lane  = 2'd3 - lo_w;
      hslot = ~lo_w[1];
    end else begin
      lane  = lo_w;
      hslot = lo_w[1];
    end
    if (is_byte_w) begin
      case (lane)
        2'd0:    m[7:0]   = data_w[7:0];
        2'd1:    m[15:8]  = data_w[7:0];
        2'd2:    m[23:16] = data_w[7:0];
        2'd3:    m[31:24] = data_w[7:0];
        default: m        = old_w;
      endcase
    end else if (hslot) begin
      m[31:16] = data_w;
    end else begin
      m[15:0] = data_w;
    end
    return m;
  endfunction

  assign req_ready = (state_r == IDLE) & ~rst;
  assign accept_s  = req_valid & req_ready;
  assign timeout_s = (TIMEOUT != 8'd0) && ((cnt_r + 8'd1) == TIMEOUT);

  // Alignment and size legality of the incoming request.
  always_comb begin
    illegal_s = 1'b0;
    case (req_size)
      2'b00:   illegal_s = 1'b0;
      2'b01:   illegal_s = req_addr[0];
      2'b10:   illegal_s = (req_addr[1:0] != 2'b00);
      default: illegal_s = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; an ack wins over a timeout reached in the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_s = IDLE;
        end else if (illegal_s) begin
          state_s = ERR;
        end else if (req_size == 2'b10) begin
          state_s = WRITE;
        end else begin
          state_s = READ;
        end
      end
      READ: begin
        if (mem_ack) begin
          state_s = WRITE;
        end else if (timeout_s) begin
          state_s = ERR;
        end else begin
          state_s = READ;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_s = DONE;
        end else if (timeout_s) begin
          state_s = ERR;
        end else begin
          state_s = WRITE;
        end
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so strobes and pulses come out of flops.
  always_comb begin
    rd_s   = 1'b0;
    wr_s   = 1'b0;
    done_s = 1'b0;
    err_s  = 1'b0;
    case (state_s)
      READ:    rd_s   = 1'b1;
      WRITE:   wr_s   = 1'b1;
      DONE:    done_s = 1'b1;
      ERR:     err_s  = 1'b1;
      default: rd_s   = 1'b0;
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      mem_rd <= rd_s;
      mem_wr <= wr_s;
      done   <= done_s;
      err    <= err_s;
    end
  end

  // Request capture, merge on read ack, and the ack-wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      data_r    <= 16'h0000;
      is_byte_r <= 1'b0;
      lo_r      <= 2'b00;
      cnt_r     <= 8'd0;
    end else begin
      if (accept_s) begin
        mem_addr  <= {req_addr[31:2], 2'b00};
        data_r    <= req_data[15:0];
        is_byte_r <= (req_size == 2'b00);
        lo_r      <= req_addr[1:0];
        if (req_size == 2'b10) begin
          mem_wdata <= req_data;
        end else begin
          mem_wdata <= mem_wdata;
        end
      end else if ((state_r == READ) && mem_ack) begin
        mem_wdata <= merge_word(mem_rdata, data_r, is_byte_r, lo_r);
      end else begin
        mem_wdata <= mem_wdata;
      end
      if (state_s != state_r) begin
        cnt_r <= 8'd0;
      end else if ((state_r == READ) || (state_r == WRITE)) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench: dut 0 is little-endian with the default timeout,
// dut 1 is big-endian with a 4-cycle ack timeout.
module tb_store_rmw_unit;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic [1:0]  req_size  [2];
  logic        done      [2];
  logic        err       [2];
  logic [31:0] mem_addr  [2];
  logic        mem_rd    [2];
  logic        mem_wr    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        mem_ack   [2];

  int total = 0;
  int bad   = 0;

  store_rmw_unit #(.BIG_ENDIAN(0), .ACK_TIMEOUT(255)) dut_le (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_data(req_data[0]), .req_size(req_size[0]), .done(done[0]), .err(err[0]),
    .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0])
  );

  store_rmw_unit #(.BIG_ENDIAN(1), .ACK_TIMEOUT(4)) dut_be (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_data(req_data[1]), .req_size(req_size[1]), .done(done[1]), .err(err[1]),
    .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full store with configurable wait states; checks strobes, address, data and latency.
  task automatic store(input int d, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size, input logic [31:0] rdata,
                       input int rwait, input int wwait, input logic [31:0] exp_w);
    int cyc;
    logic sub;
    logic [31:0] waddr;
    sub   = (size != 2'b10);
    waddr = {addr[31:2], 2'b00};
    chk("ready_before", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    req_data[d]  = data;
    req_size[d]  = size;
    tick();
    req_valid[d] = 1'b0;
    cyc = 1;
    chk("ready_busy", 32'(req_ready[d]), 32'd0);
    if (sub) begin
      for (int i = 0; i <= rwait; i++) begin
        chk("rd_held", 32'(mem_rd[d]), 32'd1);
        chk("rd_no_wr", 32'(mem_wr[d]), 32'd0);
        chk("rd_addr", mem_addr[d], waddr);
        if (i == rwait) begin
          mem_ack[d]   = 1'b1;
          mem_rdata[d] = rdata;
        end
        tick();
        cyc++;
      end
      mem_ack[d]   = 1'b0;
      mem_rdata[d] = 32'h0000_0000;
    end else begin
      chk("sw_no_rd", 32'(mem_rd[d]), 32'd0);
    end
    for (int i = 0; i <= wwait; i++) begin
      chk("wr_held", 32'(mem_wr[d]), 32'd1);
      chk("wr_no_rd", 32'(mem_rd[d]), 32'd0);
      chk("wr_addr", mem_addr[d], waddr);
      chk("wr_data", mem_wdata[d], exp_w);
      if (i == wwait) mem_ack[d] = 1'b1;
      tick();
      cyc++;
    end
    mem_ack[d] = 1'b0;
    chk("done_pulse", 32'(done[d]), 32'd1);
    chk("done_wr_low", 32'(mem_wr[d]), 32'd0);
    chk("done_ready", 32'(req_ready[d]), 32'd0);
    chk("latency", 32'(cyc), 32'((sub ? 3 : 2) + rwait + wwait));
    tick();
    chk("done_once", 32'(done[d]), 32'd0);
    chk("idle_ready", 32'(req_ready[d]), 32'd1);
  endtask

  // Rejected request: one err pulse one cycle after accept, no memory strobes.
  task automatic bad_req(input int d, input logic [31:0] addr, input logic [1:0] size);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    req_data[d]  = 32'hFFFF_FFFF;
    req_size[d]  = size;
    tick();
    req_valid[d] = 1'b0;
    chk("err_pulse", 32'(err[d]), 32'd1);
    chk("err_no_rd", 32'(mem_rd[d]), 32'd0);
    chk("err_no_wr", 32'(mem_wr[d]), 32'd0);
    chk("err_no_done", 32'(done[d]), 32'd0);
    chk("err_ready", 32'(req_ready[d]), 32'd0);
    tick();
    chk("err_once", 32'(err[d]), 32'd0);
    chk("err_idle_ready", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = 32'h0000_0000;
      req_data[i]  = 32'h0000_0000;
      req_size[i]  = 2'b00;
      mem_rdata[i] = 32'h0000_0000;
      mem_ack[i]   = 1'b0;
    end
    #2;
    chk("rst_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_rd", 32'(mem_rd[0]), 32'd0);
    chk("rst_wr", 32'(mem_wr[0]), 32'd0);
    chk("rst_addr", mem_addr[0], 32'h0000_0000);
    chk("rst_wdata", mem_wdata[0], 32'h0000_0000);
    #10;
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(req_ready[0]), 32'd1);
    chk("post_rst_done", 32'(done[0]), 32'd0);

    store(0, 32'h0000_1003, 32'hDEAD_BEEF, 2'b00, 32'h1122_3344, 0, 0, 32'hEF22_3344);
    store(0, 32'h0000_2002, 32'h0000_ABCD, 2'b01, 32'h5566_7788, 0, 0, 32'hABCD_7788);
    store(0, 32'h0000_3000, 32'hCAFE_F00D, 2'b10, 32'h0000_0000, 0, 0, 32'hCAFE_F00D);
    bad_req(0, 32'h0000_3002, 2'b10);
    store(0, 32'h0000_4001, 32'h1234_56AA, 2'b00, 32'h0102_0304, 5, 3, 32'h0102_AA04);
    store(0, 32'h0000_4000, 32'hFFFF_1357, 2'b01, 32'hA5A5_A5A5, 0, 2, 32'hA5A5_1357);
    bad_req(0, 32'h0000_5000, 2'b11);
    bad_req(0, 32'h0000_5001, 2'b01);
    store(0, 32'h0000_5002, 32'h0000_0077, 2'b00, 32'hFFFF_FFFF, 0, 0, 32'hFF77_FFFF);

    // Stray ack while idle must not start anything.
    mem_ack[0] = 1'b1;
    tick();
    mem_ack[0] = 1'b0;
    chk("idle_ack_done", 32'(done[0]), 32'd0);
    chk("idle_ack_wr", 32'(mem_wr[0]), 32'd0);
    tick();
    chk("idle_ack_done2", 32'(done[0]), 32'd0);

    store(1, 32'h0000_2002, 32'h0000_ABCD, 2'b01, 32'h5566_7788, 0, 0, 32'h5566_ABCD);
    store(1, 32'h0000_1003, 32'hDEAD_BEEF, 2'b00, 32'h1122_3344, 0, 0, 32'h1122_33EF);
    store(1, 32'h0000_1000, 32'h0000_00C3, 2'b00, 32'h1122_3344, 1, 0, 32'hC322_3344);

    // Timeout with no ack: four strobe cycles, then err with the strobe low.
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h0000_7000;
    req_size[1]  = 2'b00;
    tick();
    req_valid[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_rd_held", 32'(mem_rd[1]), 32'd1);
      chk("to_no_err", 32'(err[1]), 32'd0);
      tick();
    end
    chk("to_err", 32'(err[1]), 32'd1);
    chk("to_rd_drop", 32'(mem_rd[1]), 32'd0);
    tick();
    chk("to_err_once", 32'(err[1]), 32'd0);
    chk("to_ready", 32'(req_ready[1]), 32'd1);

    // Reset in the middle of a write abandons it without a pulse.
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_6000;
    req_data[0]  = 32'h1234_5678;
    req_size[0]  = 2'b10;
    tick();
    req_valid[0] = 1'b0;
    chk("mid_wr_high", 32'(mem_wr[0]), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_wr_drop", 32'(mem_wr[0]), 32'd0);
    chk("rst_mid_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_mid_wdata", mem_wdata[0], 32'h0000_0000);
    #2;
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(req_ready[0]), 32'd1);
    tick();
    chk("rel_done", 32'(done[0]), 32'd0);
    chk("rel_err", 32'(err[0]), 32'd0);
    chk("rel_wr", 32'(mem_wr[0]), 32'd0);
    tick();
    chk("rel_done2", 32'(done[0]), 32'd0);
    chk("rel_ready2", 32'(req_ready[0]), 32'd1);

    store(0, 32'h0000_8003, 32'h0000_0042, 2'b00, 32'h0000_0000, 0, 0, 32'h4200_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the immediate/load extension path: narrows a 32-bit register value to a byte, halfword or word and commits it to a word-only data memory.
- The data memory has no byte enables, so sub-word stores use a read-modify-write (RMW) sequence.
- Sits between the MEM stage store request and the data-memory port. Stalls the pipeline through req_ready until the store completes.

Parameters:
- BIG_ENDIAN, 0: byte-lane ordering. 0 selects lane = addr[1:0]; 1 selects lane = 3 - addr[1:0]. Halfword lane pairs follow the same rule.
- ACK_TIMEOUT, 255: maximum cycles to wait for mem_ack in any memory state before aborting with err. 0 disables the timeout. The counter is 8 bits wide.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit idle; request accepted when req_valid & req_ready.
- req_addr  input  32  byte address of the store.
- req_data  input  32  register value; only the low 8/16 bits are used for sub-word stores.
- req_size  input  2  00 = byte (SB), 01 = half (SH), 10 = word (SW), 11 = illegal.
- done  output  1  one-cycle pulse: store committed.
- err  output  1  one-cycle pulse: misaligned, illegal size, or timeout.
- mem_addr  output  32  word address {addr[31:2], 2'b00}.
- mem_rd  output  1  read strobe, held until mem_ack.
- mem_wr  output  1  write strobe, held until mem_ack.
- mem_wdata  output  32  merged write word.
- mem_rdata  input  32  read data, valid with mem_ack.
- mem_ack  input  1  memory completion for the current rd/wr.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - mem_rd, mem_wr, done, err = 0.
  - mem_addr, mem_wdata = 0; timeout counter = 0.
  - req_ready = 0 while rst is high.
  - A transaction in flight is abandoned; no write is issued after reset.
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE:
  - req_ready = 1.
  - On accept, the unit registers addr, data and size, and checks alignment.
  - Illegal if size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 0. An illegal request goes to ERR with no memory access.
  - A legal word store goes to WRITE with mem_wdata = req_data.
  - A legal byte or half store goes to READ.
- READ:
  - mem_rd = 1 and mem_addr = word address. Both are held stable until mem_ack.
  - On mem_ack, the unit captures mem_rdata, builds the merged word, registers it into mem_wdata, and goes to WRITE.
  - Byte merge: lane L is replaced by data[7:0]; the other lanes keep mem_rdata.
  - Half merge: lanes {L, L+1} (little-endian) or {L-1, L} (big-endian) are replaced by data[15:0]. Byte order within the half follows the same endianness.
- WRITE:
  - mem_wr = 1; mem_addr and mem_wdata are stable until mem_ack.
  - On mem_ack, the unit goes to DONE.
- DONE: done = 1 for one cycle, then IDLE. req_ready is 0 in this cycle.
- ERR: err = 1 for one cycle, then IDLE. req_ready is 0 in this cycle.
- mem_rd and mem_wr are never high in the same cycle. Both drop to 0 in the cycle after ack.
- Timeout:
  - The counter clears on entry to READ or WRITE and increments every cycle without mem_ack.
  - When the count reaches ACK_TIMEOUT (ACK_TIMEOUT != 0), the strobe deasserts and the unit goes to ERR. Memory content is unspecified for a WRITE timeout.
  - mem_ack in the same cycle the count reaches the limit takes precedence (success).
- Latency with zero-wait memory (ack in the first strobe cycle), measured from the accept edge:
  - Word store: done 2 cycles after accept.
  - Sub-word store: done 3 cycles after accept.
  - Illegal request: err 1 cycle after accept.
- Back-to-back: a new request can be accepted in the IDLE cycle that follows DONE/ERR. req_valid is ignored while req_ready = 0.
- mem_ack in IDLE, DONE or ERR is ignored.
- The upper bits of req_data (above the stored width) never reach memory.

Test Plan:
- Little-endian SB: addr 0x1003, data 0xDEADBEEF, memory word 0x11223344 -> READ @0x1000, WRITE 0xEF223344, done 3 cycles after accept.
- SH, BIG_ENDIAN = 1: addr 0x2002, data 0x0000ABCD, memory 0x55667788 -> WRITE 0x5566ABCD; with BIG_ENDIAN = 0 -> 0xABCD7788.
- SW: addr 0x3000, data 0xCAFEF00D -> no mem_rd, single WRITE 0xCAFEF00D, done 2 cycles after accept. SW at addr 0x3002 -> err pulse, mem_rd and mem_wr never assert.
- Wait states: mem_ack delayed 5 cycles in READ and 3 cycles in WRITE -> strobes and address held stable throughout, merged data correct, done once. ACK_TIMEOUT = 4 with no ack -> err after 4 cycles, strobe drops.
- rst asserted mid-WRITE -> mem_wr drops in the same cycle without a clock edge. After release the unit is IDLE, req_ready = 1, and no done/err pulse is emitted.
- Illegal size 11 and SH at an odd address -> err pulse. Back-to-back SB accepted in the next IDLE cycle completes normally.
